// File: rtl/timer_device.sv
// Memory-mapped timer: TH reload, TL up-counter with prescaler, TCON control/status, free-running
// systick. Zero-latency read mux; software writes take precedence over hardware updates.
module timer_device #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  input  logic        writeEn,
  output logic [31:0] deviceData,
  output logic        irq
);

  localparam logic [29:0] AddrTh      = BASE_ADDR[31:2];
  localparam logic [29:0] AddrTl      = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0] AddrTcon    = BASE_ADDR[31:2] + 30'd2;
  localparam logic [29:0] AddrSystick = BASE_ADDR[31:2] + 30'd5;
  localparam logic [15:0] PreMax      = 16'(PRESCALE - 1);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] systick_q, systick_d;
  logic [15:0] pre_q, pre_d;

  logic [29:0] word;
  logic        sel_th, sel_tl, sel_tcon, sel_systick;
  logic        tick, ovf;
  logic        unused_addr;

  assign word        = address[31:2];
  assign unused_addr = ^address[1:0];
  assign sel_th      = (word == AddrTh);
  assign sel_tl      = (word == AddrTl);
  assign sel_tcon    = (word == AddrTcon);
  assign sel_systick = (word == AddrSystick);

  assign tick = tcon_q[0] && (pre_q == PreMax);
  assign ovf  = tick && (tl_q == 32'hFFFF_FFFF);
  assign irq  = tcon_q[2];

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + 32'd1;
    pre_d     = pre_q;

    if (!tcon_q[0] || tick) begin
      pre_d = 16'd0;
    end else begin
      pre_d = pre_q + 16'd1;
    end

    if (tick) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (ovf && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end

    // Software writes are applied last so they override same-edge hardware updates.
    if (writeEn) begin
      if (sel_th)   th_d   = dataIn;
      if (sel_tl)   tl_d   = dataIn;
      if (sel_tcon) tcon_d = dataIn[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      systick_q <= 32'd0;
      pre_q     <= 16'd0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
      pre_q     <= pre_d;
    end
  end

  always_comb begin
    deviceData = 32'd0;
    if (sel_th)           deviceData = th_q;
    else if (sel_tl)      deviceData = tl_q;
    else if (sel_tcon)    deviceData = {29'd0, tcon_q};
    else if (sel_systick) deviceData = systick_q;
  end

endmodule

// File: tb/tb_timer_device.sv
// Scoreboard bench for timer_device: stimulus queues expected read data/irq, a monitor compares.
`timescale 1ns/1ps
module tb_timer_device;

  localparam logic [31:0] B       = 32'h4000_0000;
  localparam logic [31:0] TH      = B;
  localparam logic [31:0] TL      = B + 32'h4;
  localparam logic [31:0] TCON    = B + 32'h8;
  localparam logic [31:0] SYSTICK = B + 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] dataIn = 32'd0;
  logic        writeEn = 1'b0;
  logic [31:0] dd1, dd4;
  logic        irq1, irq4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    bit          unit;
    logic [31:0] data;
    bit          chk_irq;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];

  always #10 clk = ~clk;

  timer_device #(.BASE_ADDR(B), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .address(address), .dataIn(dataIn), .writeEn(writeEn),
    .deviceData(dd1), .irq(irq1)
  );

  timer_device #(.BASE_ADDR(B), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .address(address), .dataIn(dataIn), .writeEn(writeEn),
    .deviceData(dd4), .irq(irq4)
  );

  // Monitor: samples the DUT outputs once the addressed read data has settled.
  always begin
    exp_t        e;
    logic [31:0] act;
    logic        act_irq;
    wait (exp_q.size() != 0);
    #1;
    e       = exp_q.pop_front();
    act     = e.unit ? dd4 : dd1;
    act_irq = e.unit ? irq4 : irq1;
    n_checks++;
    if (act !== e.data) begin
      n_errors++;
      $display("FAIL %s: data got %08h expected %08h", e.name, act, e.data);
    end
    if (e.chk_irq) begin
      n_checks++;
      if (act_irq !== e.irq) begin
        n_errors++;
        $display("FAIL %s: irq got %0b expected %0b", e.name, act_irq, e.irq);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    dataIn  = d;
    writeEn = 1'b1;
    @(posedge clk);
    #1;
    writeEn = 1'b0;
  endtask

  task automatic chk(input string name, input bit unit, input logic [31:0] a,
                     input logic [31:0] d, input bit ci, input logic iv);
    exp_t e;
    address   = a;
    writeEn   = 1'b0;
    e.name    = name;
    e.unit    = unit;
    e.data    = d;
    e.chk_irq = ci;
    e.irq     = iv;
    exp_q.push_back(e);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_tl", 0, TL, 32'd0, 1, 1'b0);
    chk("rst_tcon", 0, TCON, 32'd0, 0, 1'b0);
    chk("rst_systick", 0, SYSTICK, 32'd0, 0, 1'b0);
    cyc(2);
    rst = 1'b1;

    // Basic count and overflow with IE=1, PRESCALE=1
    wr(TH, 32'hFFFF_FFFD);
    wr(TL, 32'hFFFF_FFFE);
    wr(TCON, 32'd3);
    chk("cnt_start", 0, TL, 32'hFFFF_FFFE, 1, 1'b0);
    cyc(1);
    chk("cnt_ffff", 0, TL, 32'hFFFF_FFFF, 1, 1'b0);
    cyc(1);
    chk("ovf_reload", 0, TL, 32'hFFFF_FFFD, 0, 1'b0);
    chk("ovf_tcon", 0, TCON, 32'd7, 1, 1'b1);
    wr(TCON, 32'd3);
    chk("if_clear", 0, TCON, 32'd3, 1, 1'b0);
    chk("if_clear_tl", 0, TL, 32'hFFFF_FFFE, 0, 1'b0);
    wr(TCON, 32'd0);

    // Overflow with IE=0 reloads but leaves IF clear
    wr(TH, 32'd5);
    wr(TL, 32'hFFFF_FFFF);
    wr(TCON, 32'd1);
    cyc(1);
    chk("noie_tl", 0, TL, 32'd5, 0, 1'b0);
    chk("noie_tcon", 0, TCON, 32'd1, 1, 1'b0);
    wr(TCON, 32'd0);
    chk("noie_freeze", 0, TL, 32'd6, 0, 1'b0);

    // TL write on a tick edge wins over the increment
    wr(TL, 32'd0);
    wr(TCON, 32'd1);
    wr(TL, 32'h10);
    chk("col_tl", 0, TL, 32'h10, 0, 1'b0);
    cyc(1);
    chk("col_tl_next", 0, TL, 32'h11, 0, 1'b0);
    wr(TCON, 32'd0);

    // TH write on an overflow edge: TL reloads with the old TH
    wr(TH, 32'd7);
    wr(TL, 32'hFFFF_FFFE);
    wr(TCON, 32'd1);
    cyc(1);
    wr(TH, 32'h99);
    chk("col_th_tl", 0, TL, 32'd7, 0, 1'b0);
    chk("col_th_th", 0, TH, 32'h99, 0, 1'b0);
    wr(TCON, 32'd0);
    chk("col_th_freeze", 0, TL, 32'd8, 0, 1'b0);

    // TCON write on an overflow edge drops the IF set
    wr(TL, 32'hFFFF_FFFE);
    wr(TCON, 32'd3);
    cyc(1);
    wr(TCON, 32'd3);
    chk("col_tcon", 0, TCON, 32'd3, 1, 1'b0);
    chk("col_tcon_tl", 0, TL, 32'h99, 0, 1'b0);
    wr(TCON, 32'd0);

    // IF is sticky; clearing IE does not clear it
    wr(TL, 32'hFFFF_FFFF);
    wr(TCON, 32'd3);
    cyc(1);
    chk("sticky_set", 0, TCON, 32'd7, 1, 1'b1);
    wr(TCON, 32'd5);
    chk("sticky_ie0", 0, TCON, 32'd5, 1, 1'b1);
    chk("sticky_tl", 0, TL, 32'h9A, 0, 1'b0);
    wr(TCON, 32'd4);

    // Asynchronous reset mid-operation
    wr(TL, 32'h1234);
    chk("pre_rst_tl", 0, TL, 32'h1234, 1, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_tl", 0, TL, 32'd0, 1, 1'b0);
    chk("arst_tcon", 0, TCON, 32'd0, 0, 1'b0);
    chk("arst_th", 0, TH, 32'd0, 0, 1'b0);
    rst = 1'b1;

    // Systick is read-only and free-running; decode holes read 0
    cyc(1);
    wr(SYSTICK, 32'hDEAD_0000);
    chk("systick_wr", 0, SYSTICK, 32'd2, 0, 1'b0);
    cyc(1);
    chk("systick_inc", 0, SYSTICK, 32'd3, 0, 1'b0);
    chk("hole_0c", 0, B + 32'h0C, 32'd0, 0, 1'b0);
    chk("hole_100", 0, B + 32'h100, 32'd0, 0, 1'b0);
    wr(TL, 32'hCAFE_0001);
    chk("misalign_tl", 0, TL + 32'd3, 32'hCAFE_0001, 0, 1'b0);
    chk("misalign_systick", 0, SYSTICK + 32'd3, 32'd4, 0, 1'b0);

    // PRESCALE=4 unit: ticks 4 and 8 cycles after enabling, freezes on EN=0
    wr(TL, 32'd0);
    wr(TCON, 32'd1);
    cyc(3);
    chk("ps_3", 1, TL, 32'd0, 0, 1'b0);
    cyc(1);
    chk("ps_4", 1, TL, 32'd1, 0, 1'b0);
    cyc(3);
    chk("ps_7", 1, TL, 32'd1, 0, 1'b0);
    cyc(1);
    chk("ps_8", 1, TL, 32'd2, 0, 1'b0);
    wr(TCON, 32'd0);
    cyc(10);
    chk("ps_frozen", 1, TL, 32'd2, 1, 1'b0);
    wr(TCON, 32'd1);
    cyc(3);
    chk("ps_re_3", 1, TL, 32'd2, 0, 1'b0);
    cyc(1);
    chk("ps_re_4", 1, TL, 32'd3, 0, 1'b0);

    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped timer/interrupt peripheral on the CPU data bus; drives the CPU's `deviceData` read path; also decodes CPU writes on the shared address/data bus.
- Holds a reload register TH, a counter TL, a control/status register TCON and a free-running systick counter.
- Raises a level interrupt request when TL overflows with interrupt enabled.
- Clocked from the divided system clock, same clock as CPU and LED.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of TH; TL = +4, TCON = +8, SYSTICK = +20 (0x14).
- PRESCALE, 1, TL advances once every PRESCALE enabled clocks; legal range 1..65535.

Ports:
- clk  input  1  system clock (divided clock), rising-edge.
- rst  input  1  reset; asynchronous and active-low.
- address  input  32  CPU data address; word-aligned, bits [1:0] ignored.
- dataIn  input  32  CPU write data.
- writeEn  input  1  CPU store strobe; sampled on clk rising edge.
- deviceData  output  32  read data for the addressed register; 0 when no register is matched.
- irq  output  1  interrupt request; equals TCON[2].

Behaviour:
- Reset (rst=0, asynchronous): TH=0, TL=0, TCON=0, SYSTICK=0, prescale counter=0; therefore deviceData=0 when unmatched and irq=0 immediately, without waiting for a clock edge.
- TCON layout:
  - bit0 EN: count enable.
  - bit1 IE: interrupt enable.
  - bit2 IF: interrupt flag.
  - bits [31:3] read as 0.
- Reads are combinational, zero latency: deviceData = mux(address) among TH, TL, {29'b0, TCON}, SYSTICK; 0 for any other address.
- Writes happen on a clk edge with writeEn=1 and a matching address:
  - TH and TL take the full 32 bits.
  - TCON takes dataIn[2:0]; software clears IF by writing 0 to bit2.
  - SYSTICK is read-only; writes are ignored.
- SYSTICK increments by 1 every clk edge out of reset and wraps 0xFFFF_FFFF -> 0.
- Prescaler: while EN=1, the prescale counter counts 0..PRESCALE-1 and asserts an internal tick when it is at PRESCALE-1, then returns to 0. With PRESCALE=1, a tick occurs every cycle.
- While EN=0, the prescale counter holds at 0; TL and IF are frozen.
- On a tick:
  - If TL != 0xFFFF_FFFF: TL <= TL+1.
  - If TL == 0xFFFF_FFFF: TL <= TH (reload). If IE=1, IF <= 1 on the same edge.
- IF is sticky until software clears it. An overflow with IE=0 does not set IF. Clearing IE does not clear IF.
- Simultaneous software write and hardware update to the same register: the software write wins.
  - Writing TL on a tick edge: TL = dataIn, no increment.
  - Writing TCON on an overflow edge: TCON = dataIn[2:0], overflow-set of IF lost.
  - Other registers still update normally on that edge, e.g. writing TH on an overflow edge: TL reloads with the OLD TH.
- Enabling EN: the first tick occurs PRESCALE cycles after the write edge.
- Reset asserted mid-count clears all state asynchronously; counting resumes only after software re-enables EN.
- irq is a registered level: asserted the cycle after the overflow edge, deasserted the cycle after the clearing write.

Test Plan:
- Reset: drive rst=0 mid-operation with TL=0x1234, IF=1 -> TL=0, irq=0, deviceData@TCON=0 before the next clk edge.
- Basic count, PRESCALE=1:
  - Stimulus: write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3.
  - Response: TL reads 0xFFFF_FFFF after 1 cycle; on the 2nd edge TL=0xFFFF_FFFD, TCON=7, irq=1.
  - Then write TCON=3 -> irq=0 the next cycle.
- IE=0 overflow: TCON=1, TL=0xFFFF_FFFF, TH=5 -> next edge TL=5, IF=0, irq stays 0.
- Prescale with PRESCALE=4: after EN=1 write, TL increments 0->1 exactly 4 cycles later, 1->2 after 8; setting EN=0 freezes TL.
- Collisions:
  - Tick edge with TL write of 0x10 -> TL=0x10.
  - Overflow edge with TH write of 0x99 (old TH=0x7) -> TL=0x7, then TH reads 0x99.
- Decode: read BASE+0x0C and BASE+0x100 -> 0. Write SYSTICK -> ignored, it keeps incrementing. Reading address with bits[1:0]=2'b11 at TL -> TL value.
